// File: rtl/updown_mod_counter_if.sv
// Bus bundle for updown_mod_counter: control/data inputs and count/flag outputs.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             sat;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (
        output en, up_down, load, load_val, limit, sat, clr_flags,
        input  count, tc, ovf, unf
    );

    modport slave (
        input  en, up_down, load, load_val, limit, sat, clr_flags,
        output count, tc, ovf, unf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..limit with wrap/saturate, load, and ovf/unf flags.
// Define UDC_STICKY_FLAGS_EN to make ovf/unf sticky until clr_flags.
module updown_mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    updown_mod_counter_if.slave  bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_evt;
    logic             unf_evt;

    always_comb begin
        count_d = count_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_down) begin
                // Compare before incrementing so limit = all-ones never carries out.
                if (count_q < bus.limit) begin
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                    if (bus.sat && (count_q == bus.limit))
                        count_d = count_q;
                    else
                        count_d = '0;
                end
            end else begin
                if (count_q > bus.limit) begin
                    count_d = bus.limit;
                end else if (count_q == '0) begin
                    unf_evt = 1'b1;
                    count_d = bus.sat ? '0 : bus.limit;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

`ifdef UDC_STICKY_FLAGS_EN
    // A new event wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_evt | (ovf_q & ~bus.clr_flags);
        unf_d = unf_evt | (unf_q & ~bus.clr_flags);
    end
`else
    always_comb begin
        ovf_d = ovf_evt;
        unf_d = unf_evt;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
    assign bus.tc    = bus.up_down ? (count_q == bus.limit) : (count_q == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter at WIDTH=4, both flag modes.
module tb_updown_mod_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(W)) bus ();

    updown_mod_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int    count;
        int    ovf;
        int    unf;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    int m_count = 0;
    int m_ovf = 0;
    int m_unf = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock transaction: drive, check tc, push expected, clock, pop and compare.
    task automatic cycle(input string tag, input bit rn, input bit e, input bit ud,
                         input bit ld, input int lv, input int lim, input bit s,
                         input bit clr);
        int   nc;
        int   ov;
        int   un;
        exp_t ex;
        exp_t got;
        reset_n       = rn;
        bus.en        = e;
        bus.up_down   = ud;
        bus.load      = ld;
        bus.load_val  = lv[W-1:0];
        bus.limit     = lim[W-1:0];
        bus.sat       = s;
        bus.clr_flags = clr;
        #1;
        if (rn)
            check_val({tag, "_tc"}, int'(bus.tc), ud ? int'(m_count == lim) : int'(m_count == 0));
        nc = m_count;
        ov = 0;
        un = 0;
        if (ld) begin
            nc = (lv < lim) ? lv : lim;
        end else if (e && ud) begin
            if (m_count >= lim) begin
                ov = 1;
                nc = (s && m_count == lim) ? m_count : 0;
            end else begin
                nc = m_count + 1;
            end
        end else if (e) begin
            if (m_count > lim) nc = lim;
            else if (m_count == 0) begin
                un = 1;
                nc = s ? 0 : lim;
            end else nc = m_count - 1;
        end
        if (!rn) begin
            nc    = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
`ifdef UDC_STICKY_FLAGS_EN
            m_ovf = (ov != 0 || (m_ovf != 0 && !clr)) ? 1 : 0;
            m_unf = (un != 0 || (m_unf != 0 && !clr)) ? 1 : 0;
`else
            m_ovf = ov;
            m_unf = un;
`endif
        end
        m_count = nc;
        ex.count = m_count;
        ex.ovf   = m_ovf;
        ex.unf   = m_unf;
        ex.tag   = tag;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        $display("[TB] %s count=%0d ovf=%0d unf=%0d tc=%0d (exp %0d/%0d/%0d)",
                 got.tag, bus.count, bus.ovf, bus.unf, bus.tc, got.count, got.ovf, got.unf);
        check_val({got.tag, "_count"}, int'(bus.count), got.count);
        check_val({got.tag, "_ovf"}, int'(bus.ovf), got.ovf);
        check_val({got.tag, "_unf"}, int'(bus.unf), got.unf);
    endtask

    initial begin
        int seq_ovf;
        int tp1_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        cycle("rst0", 0, 1, 1, 0, 0, 9, 0, 0);
        cycle("rst1", 0, 1, 1, 1, 7, 9, 0, 0);
        check_val("rst_count", int'(bus.count), 0);

        // Wrap up through limit 9.
        seq_ovf = 0;
        for (int i = 0; i < 12; i++) begin
            cycle($sformatf("up9_%0d", i), 1, 1, 1, 0, 0, 9, 0, 0);
            check_val($sformatf("up9_dir_%0d", i), int'(bus.count), tp1_exp[i]);
            seq_ovf += int'(bus.ovf);
        end
`ifndef UDC_STICKY_FLAGS_EN
        check_val("up9_ovf_pulses", seq_ovf, 1);
`endif

        // Saturating up then down.
        cycle("ld8", 1, 0, 1, 1, 8, 9, 1, 1);
        for (int i = 0; i < 3; i++) cycle($sformatf("satup_%0d", i), 1, 1, 1, 0, 0, 9, 1, 0);
        check_val("satup_dir", int'(bus.count), 9);
        cycle("ld1", 1, 0, 0, 1, 1, 9, 1, 1);
        for (int i = 0; i < 3; i++) cycle($sformatf("satdn_%0d", i), 1, 1, 0, 0, 0, 9, 1, 0);
        check_val("satdn_dir", int'(bus.count), 0);
        check_val("satdn_unf_dir", int'(bus.unf), 1);

        // Load clamp and load priority over enable.
        cycle("ld13", 1, 0, 1, 1, 13, 9, 0, 1);
        check_val("ld13_dir", int'(bus.count), 9);
        cycle("ld4en", 1, 1, 1, 1, 4, 9, 0, 0);
        check_val("ld4en_dir", int'(bus.count), 4);

        // Out of range after lowering limit.
        cycle("ld7a", 1, 0, 1, 1, 7, 9, 0, 0);
        cycle("oor_up", 1, 1, 1, 0, 0, 5, 0, 0);
        check_val("oor_up_dir", int'(bus.count), 0);
        cycle("ld7b", 1, 0, 1, 1, 7, 9, 0, 1);
        cycle("oor_dn", 1, 1, 0, 0, 0, 5, 0, 0);
        check_val("oor_dn_dir", int'(bus.count), 5);

        // Synchronous reset mid-count, then a between-edges glitch.
        cycle("ld5", 1, 0, 1, 1, 5, 9, 0, 1);
        cycle("to6", 1, 1, 1, 0, 0, 9, 0, 0);
        cycle("rst_mid", 0, 1, 1, 0, 0, 9, 0, 0);
        cycle("ld6", 1, 0, 1, 1, 6, 9, 0, 0);
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        #1;
        check_val("glitch_count", int'(bus.count), 6);
        cycle("after_glitch", 1, 0, 1, 0, 0, 9, 0, 0);

        // limit == 0 and full-range limit.
        cycle("ld0", 1, 0, 1, 1, 3, 0, 0, 1);
        cycle("lim0_up", 1, 1, 1, 0, 0, 0, 0, 0);
        cycle("lim0_dn", 1, 1, 0, 0, 0, 0, 0, 1);
        cycle("ld14", 1, 0, 1, 1, 14, 15, 0, 1);
        cycle("lim15_a", 1, 1, 1, 0, 0, 15, 0, 0);
        cycle("lim15_b", 1, 1, 1, 0, 0, 15, 0, 0);
        check_val("lim15_wrap_dir", int'(bus.count), 0);
        cycle("lim15_dn", 1, 1, 0, 0, 0, 15, 0, 1);
        check_val("lim15_dn_dir", int'(bus.count), 15);

        // Flag persistence, clear, and clear concurrent with an event.
        cycle("ld9", 1, 0, 1, 1, 9, 9, 0, 1);
        cycle("wrap9", 1, 1, 1, 0, 0, 9, 0, 0);
        for (int i = 0; i < 5; i++) cycle($sformatf("idle_%0d", i), 1, 0, 1, 0, 0, 9, 0, 0);
`ifdef UDC_STICKY_FLAGS_EN
        check_val("sticky_hold_dir", int'(bus.ovf), 1);
`else
        check_val("pulse_hold_dir", int'(bus.ovf), 0);
`endif
        cycle("clr", 1, 0, 1, 0, 0, 9, 0, 1);
        check_val("clr_dir", int'(bus.ovf), 0);
        cycle("ld9b", 1, 0, 1, 1, 9, 9, 0, 0);
        cycle("wrap_clr", 1, 1, 1, 0, 0, 9, 0, 1);
        check_val("wrap_clr_dir", int'(bus.ovf), 1);
        cycle("idle_end", 1, 0, 1, 0, 0, 9, 0, 0);

        check_val("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised up/down counter that generalises the basic 3-bit up/down counter.
- Adds configurable width, a runtime modulo limit, wrap or saturate mode, parallel load, count enable, a terminal-count flag and overflow/underflow flags.
- Used as a general-purpose event, index or timer counter in the datapath and lab designs.

Parameters:
- WIDTH, 8, counter/limit/load width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- en  input  1  count enable; one step per cycle while high
- up_down  input  1  1 = count up, 0 = count down
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- limit  input  WIDTH  top of count range; valid range is 0..limit inclusive
- sat  input  1  0 = wrap at range ends, 1 = saturate at range ends
- clr_flags  input  1  clears sticky flags (used only when UDC_STICKY_FLAGS_EN is defined)
- count  output  WIDTH  registered counter value
- tc  output  1  terminal count, combinational
- ovf  output  1  overflow flag, registered
- unf  output  1  underflow flag, registered

Behaviour:
- Reset: reset_n low at a rising clk edge sets count=0, ovf=0, unf=0. Reset is synchronous only; no asynchronous path. Reset overrides all other inputs.
- Priority per edge: reset_n low > load > en > hold.
- Load: count <= min(load_val, limit). ovf and unf are unaffected by load (pulse mode: both 0 that cycle). en is ignored while load=1.
- Up step (en=1, up_down=1):
  - count < limit: count+1.
  - count == limit, sat=0: count <= 0, ovf=1.
  - count == limit, sat=1: count holds, ovf=1.
- Down step (en=1, up_down=0):
  - count > 0: count-1.
  - count == 0, sat=0: count <= limit, unf=1.
  - count == 0, sat=1: count holds at 0, unf=1.
- Out of range (count > limit, e.g. limit lowered at runtime), with en=1:
  - Up: count <= 0, ovf=1.
  - Down: count <= limit, no flag.
- limit == 0: count stays 0. Every enabled up step raises ovf; every enabled down step raises unf.
- Hold: en=0 and load=0 means count holds.
- tc = (up_down ? count == limit : count == 0). Purely combinational from count, up_down and limit; valid whenever reset_n=1.
- Arithmetic is unsigned modulo 2^WIDTH internally. No carry escapes; compare against limit before incrementing so limit = 2^WIDTH-1 wraps correctly.
- Latency: count, ovf and unf update one clk edge after the qualifying inputs are sampled.

Optional Feature:
- Macro: UDC_STICKY_FLAGS_EN.
- Defined: ovf and unf are sticky. Each is set by its event and held until clr_flags=1 or reset.
  - If clr_flags and a new event occur in the same cycle, set wins and the flag stays 1.
  - clr_flags clears both flags.
- Not defined: ovf and unf are single-cycle pulses, high only in the cycle after the event. clr_flags is ignored; the port stays present so instantiations are identical.

Test Plan:
- WIDTH=4, limit=9, sat=0, en=1, up_down=1, 12 cycles from reset -> count 1..9, then 0, 1, 2; tc=1 while count=9; ovf pulses once, in the cycle count shows 0.
- limit=9, sat=1, start count=8, up 3 cycles -> count 9, 9, 9; ovf=1 on the 2nd and 3rd steps; then down_up=0 from count=1 for 3 steps -> 0, 0, 0 with unf=1 on the 2nd and 3rd.
- load=1, load_val=13, limit=9 -> count=9 next cycle. load=1 and en=1 simultaneously with load_val=4 -> count=4 (load wins).
- count=7, limit changed to 5, en=1, up -> count=0, ovf=1. Repeat with down from count=7 -> count=5, no flag.
- Drive reset_n=0 for one edge mid-count at count=6 with en=1 -> count=0, ovf=0, unf=0 on that edge. Assert reset_n low between edges only -> no effect (synchronous).
- UDC_STICKY_FLAGS_EN defined: wrap up from 9 -> ovf stays 1 across 5 idle cycles. clr_flags=1 -> ovf=0 next cycle. clr_flags concurrent with a wrap -> ovf stays 1. Macro undefined: same stimulus -> one-cycle pulse, clr_flags has no effect.
